// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package    : lc3b_types
// Description: Shared types and constants for the LC-3b pipeline controller:
//              scoreboard entry layout and forward-select encodings.
// Revision   : 1.0 - initial release
// ============================================================================
package lc3b_types;

  // Default operand geometry; pipe_ctrl's AW / NUM_SRC must agree with these
  // because the scoreboard entry is a fixed packed struct.
  localparam int SB_AW      = 3;
  localparam int SB_NUM_SRC = 2;

  // Forward-select encodings: 0 means "use register-file value", any other
  // value k means "take the result held in scoreboard stage k".
  localparam int FWD_RF  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  typedef struct packed {
    logic                         valid;
    logic                         we;
    logic                         is_load;
    logic [SB_AW-1:0]             dest;
    logic [SB_NUM_SRC*SB_AW-1:0]  sr;
    logic [SB_NUM_SRC-1:0]        sr_used;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/youngest_match.sv
`default_nettype none
// ============================================================================
// Module     : youngest_match
// Description: Finds the youngest (lowest index >= LO) scoreboard stage that
//              writes a given source register; returns hit, index, is_load.
// Revision   : 1.0 - initial release
// ============================================================================
module youngest_match
  import lc3b_types::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int AW         = SB_AW,
  parameter int LO         = 0,
  localparam int FW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic [AW-1:0]            src,
  input  logic                     src_used,
  input  logic [NUM_STAGES-1:0]    valid,
  input  logic [NUM_STAGES-1:0]    we,
  input  logic [NUM_STAGES-1:0]    is_load_vec,
  input  logic [NUM_STAGES*AW-1:0] dest,
  output logic                     hit,
  output logic [FW-1:0]            idx,
  output logic                     is_load
);

  // Scan oldest to youngest so the last (lowest-index) match wins.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int k = NUM_STAGES - 1; k >= LO; k--) begin
      if (src_used && valid[k] && we[k] && (dest[k*AW +: AW] == src)) begin
        hit     = 1'b1;
        idx     = FW'(k);
        is_load = is_load_vec[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : pipe_ctrl
// Description: Pipeline controller: scoreboard of in-flight instructions,
//              load-use hazard detection, stall/flush enables, EX forwarding
//              selects and saturating hazard/flush event counters.
// Revision   : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import lc3b_types::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int NUM_SRC        = SB_NUM_SRC,
  parameter int AW             = SB_AW,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int REDIRECT_STAGE = 2,
  parameter int CNT_W          = 16,
  localparam int FW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    icache_stall,
  input  logic                    dcache_stall,
  input  logic                    redirect,
  input  logic [NUM_SRC*AW-1:0]   id_sr,
  input  logic [NUM_SRC-1:0]      id_sr_used,
  input  logic [AW-1:0]           id_dest,
  input  logic                    id_we,
  input  logic                    id_is_load,
  output logic                    load_pc,
  output logic                    load_if_id,
  output logic                    flush_if_id,
  output logic                    pipe_adv,
  output logic                    ex_bubble,
  output logic                    ifid_valid,
  output logic [NUM_STAGES-1:0]   stage_valid,
  output logic [NUM_SRC*FW-1:0]   fwd_sel,
  output logic [CNT_W-1:0]        hazard_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  sb_entry_t                r_sb [NUM_STAGES];
  logic                     r_ifid_valid;
  logic [CNT_W-1:0]         r_hazard_cnt;
  logic [CNT_W-1:0]         r_flush_cnt;

  logic [NUM_STAGES-1:0]    w_v;
  logic [NUM_STAGES-1:0]    w_we;
  logic [NUM_STAGES-1:0]    w_ld;
  logic [NUM_STAGES*AW-1:0] w_dest;
  logic [NUM_SRC-1:0]       w_id_hit;
  logic [NUM_SRC-1:0]       w_id_ld;
  logic [NUM_SRC-1:0]       w_src_hz;
  logic [NUM_SRC-1:0]       w_ex_hit;
  logic [NUM_SRC-1:0]       w_ex_ld;
  logic [NUM_SRC*FW-1:0]    w_id_idx;
  logic [NUM_SRC*FW-1:0]    w_ex_idx;
  logic                     w_adv;
  logic                     w_hazard;
  logic                     w_bubble;
  logic                     w_load_if_id;
  sb_entry_t                w_id_entry;

  // Flatten scoreboard fields into vectors for the match units.
  generate
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_flat
      assign w_v[k]               = r_sb[k].valid;
      assign w_we[k]              = r_sb[k].we;
      assign w_ld[k]              = r_sb[k].is_load;
      assign w_dest[k*AW +: AW]   = r_sb[k].dest;
    end
  endgenerate

  // Per-source matching: ID side searches all stages, EX side skips stage 0
  // (which is the EX instruction itself).
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      youngest_match #(
        .NUM_STAGES (NUM_STAGES),
        .AW         (AW),
        .LO         (0)
      ) u_id_match (
        .src         (id_sr[i*AW +: AW]),
        .src_used    (id_sr_used[i]),
        .valid       (w_v),
        .we          (w_we),
        .is_load_vec (w_ld),
        .dest        (w_dest),
        .hit         (w_id_hit[i]),
        .idx         (w_id_idx[i*FW +: FW]),
        .is_load     (w_id_ld[i])
      );

      // Load data is not available until LOAD_FWD_STAGE; the consumer must
      // wait if it would reach EX before the load gets there.
      assign w_src_hz[i] = w_id_hit[i] & w_id_ld[i] &
                           (int'(w_id_idx[i*FW +: FW]) < LOAD_FWD_STAGE - 1);

      youngest_match #(
        .NUM_STAGES (NUM_STAGES),
        .AW         (AW),
        .LO         (1)
      ) u_ex_match (
        .src         (r_sb[0].sr[i*AW +: AW]),
        .src_used    (r_sb[0].valid & r_sb[0].sr_used[i]),
        .valid       (w_v),
        .we          (w_we),
        .is_load_vec (w_ld),
        .dest        (w_dest),
        .hit         (w_ex_hit[i]),
        .idx         (w_ex_idx[i*FW +: FW]),
        .is_load     (w_ex_ld[i])
      );

      // A load not yet at LOAD_FWD_STAGE has no data to forward; the hazard
      // stall keeps this from happening, the guard just keeps the mux honest.
      assign fwd_sel[i*FW +: FW] =
        (w_ex_hit[i] && !(w_ex_ld[i] && (int'(w_ex_idx[i*FW +: FW]) < LOAD_FWD_STAGE)))
          ? w_ex_idx[i*FW +: FW] : FW'(FWD_RF);
    end
  endgenerate

  assign w_adv        = ~dcache_stall;
  assign w_hazard     = r_ifid_valid & (|w_src_hz);
  assign w_bubble     = ~(r_ifid_valid & ~w_hazard & ~redirect);
  assign w_load_if_id = w_adv & ~icache_stall & ~w_hazard & ~redirect;

  assign pipe_adv     = w_adv;
  assign load_if_id   = w_load_if_id;
  assign load_pc      = w_adv & (redirect | (~icache_stall & ~w_hazard));
  assign flush_if_id  = w_adv & redirect;
  assign ex_bubble    = w_bubble;
  assign ifid_valid   = r_ifid_valid;
  assign stage_valid  = w_v;
  assign hazard_cnt   = r_hazard_cnt;
  assign flush_cnt    = r_flush_cnt;

  // Scoreboard entry built from the instruction currently in ID.
  always_comb begin
    w_id_entry         = '0;
    w_id_entry.valid   = 1'b1;
    w_id_entry.we      = id_we;
    w_id_entry.is_load = id_is_load;
    w_id_entry.dest    = id_dest;
    w_id_entry.sr      = id_sr;
    w_id_entry.sr_used = id_sr_used;
  end

  // Scoreboard shift; redirect kills the wrong-path stages on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) r_sb[k] <= '0;
    end else if (w_adv) begin
      r_sb[0] <= w_bubble ? '0 : w_id_entry;
      for (int k = 1; k < NUM_STAGES; k++) r_sb[k] <= r_sb[k-1];
      if (redirect) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (k <= REDIRECT_STAGE) r_sb[k] <= '0;
        end
      end
    end
  end

  // IF/ID live flag: refill sets it, draining to EX without refill clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifid_valid <= 1'b0;
    end else if (w_adv) begin
      if (redirect)          r_ifid_valid <= 1'b0;
      else if (w_load_if_id) r_ifid_valid <= 1'b1;
      else if (!w_bubble)    r_ifid_valid <= 1'b0;
    end
  end

  // Saturating event counters, frozen while the pipe is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hazard_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (w_adv) begin
      if (w_hazard && (r_hazard_cnt != '1)) r_hazard_cnt <= r_hazard_cnt + 1'b1;
      if (redirect && (r_flush_cnt  != '1)) r_flush_cnt  <= r_flush_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_pipe_ctrl
// Description: Directed self-checking bench for pipe_ctrl. A second instance
//              with a 4-bit counter width shares all inputs so counter
//              saturation can be reached within a short run.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int NS   = 3;
  localparam int NSRC = 2;
  localparam int AW   = 3;
  localparam int FW   = 2;
  localparam int CW   = 16;
  localparam int CWN  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              icache_stall;
  logic              dcache_stall;
  logic              redirect;
  logic [NSRC*AW-1:0] id_sr;
  logic [NSRC-1:0]   id_sr_used;
  logic [AW-1:0]     id_dest;
  logic              id_we;
  logic              id_is_load;

  logic              load_pc, load_if_id, flush_if_id, pipe_adv, ex_bubble, ifid_valid;
  logic [NS-1:0]     stage_valid;
  logic [NSRC*FW-1:0] fwd_sel;
  logic [CW-1:0]     hazard_cnt, flush_cnt;

  logic              n_load_pc, n_load_if_id, n_flush_if_id, n_pipe_adv, n_ex_bubble, n_ifid_valid;
  logic [NS-1:0]     n_stage_valid;
  logic [NSRC*FW-1:0] n_fwd_sel;
  logic [CWN-1:0]    n_hazard_cnt, n_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .redirect(redirect), .id_sr(id_sr), .id_sr_used(id_sr_used), .id_dest(id_dest),
    .id_we(id_we), .id_is_load(id_is_load), .load_pc(load_pc), .load_if_id(load_if_id),
    .flush_if_id(flush_if_id), .pipe_adv(pipe_adv), .ex_bubble(ex_bubble),
    .ifid_valid(ifid_valid), .stage_valid(stage_valid), .fwd_sel(fwd_sel),
    .hazard_cnt(hazard_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(CWN)) dut_n (
    .clk(clk), .reset(reset), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .redirect(redirect), .id_sr(id_sr), .id_sr_used(id_sr_used), .id_dest(id_dest),
    .id_we(id_we), .id_is_load(id_is_load), .load_pc(n_load_pc), .load_if_id(n_load_if_id),
    .flush_if_id(n_flush_if_id), .pipe_adv(n_pipe_adv), .ex_bubble(n_ex_bubble),
    .ifid_valid(n_ifid_valid), .stage_valid(n_stage_valid), .fwd_sel(n_fwd_sel),
    .hazard_cnt(n_hazard_cnt), .flush_cnt(n_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic we, input logic ld, input logic [2:0] dst,
                        input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used);
    id_we      = we;
    id_is_load = ld;
    id_dest    = dst;
    id_sr      = {s1, s0};
    id_sr_used = used;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; icache_stall = 1'b0; dcache_stall = 1'b0; redirect = 1'b0;
    set_id(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00);
    cyc();
    check("rst_stage_valid", stage_valid, 3'b000);
    check("rst_fwd_sel",     fwd_sel,     4'h0);
    check("rst_ex_bubble",   ex_bubble,   1'b1);
    check("rst_ifid_valid",  ifid_valid,  1'b0);
    check("rst_hazard_cnt",  hazard_cnt,  16'h0);
    check("rst_flush_cnt",   flush_cnt,   16'h0);
    reset = 1'b0;

    // Load-use: LDR R1 into EX, then ADD R2,R1,R3 in ID stalls one cycle.
    set_id(1'b1, 1'b1, 3'd1, 3'd6, 3'd0, 2'b01);
    cyc();
    check("fill_ifid_valid", ifid_valid, 1'b1);
    check("fill_ex_bubble",  ex_bubble,  1'b0);
    cyc();
    set_id(1'b1, 1'b0, 3'd2, 3'd1, 3'd3, 2'b11);
    #1;
    check("lu_ex_bubble",  ex_bubble,   1'b1);
    check("lu_load_pc",    load_pc,     1'b0);
    check("lu_load_if_id", load_if_id,  1'b0);
    check("lu_stage",      stage_valid, 3'b001);
    cyc();
    check("lu_hazard_cnt", hazard_cnt,  16'd1);
    check("lu_stage2",     stage_valid, 3'b010);
    check("lu_released",   ex_bubble,   1'b0);
    check("lu_load_pc2",   load_pc,     1'b1);
    cyc();
    check("lu_fwd_wb",     fwd_sel,     4'h2);
    check("lu_stage3",     stage_valid, 3'b101);

    // Two writers of R1 in MEM and WB; consumer in EX takes the younger (MEM).
    set_id(1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 2'b00);
    cyc();
    cyc();
    set_id(1'b1, 1'b0, 3'd7, 3'd1, 3'd1, 2'b11);
    #1;
    check("yw_no_hazard",  ex_bubble,   1'b0);
    cyc();
    check("yw_fwd_mem",    fwd_sel,     4'h5);
    check("yw_stage",      stage_valid, 3'b111);

    // Fetch stall with a valid ADD in IF/ID: it drains once, then bubbles.
    set_id(1'b1, 1'b0, 3'd3, 3'd0, 3'd0, 2'b00);
    icache_stall = 1'b1;
    #1;
    check("ic_load_if_id", load_if_id,  1'b0);
    check("ic_load_pc",    load_pc,     1'b0);
    check("ic_ex_bubble0", ex_bubble,   1'b0);
    cyc();
    check("ic_ifid_clr",   ifid_valid,  1'b0);
    check("ic_ex_bubble1", ex_bubble,   1'b1);
    check("ic_stage1",     stage_valid, 3'b111);
    cyc();
    check("ic_stage2",     stage_valid, 3'b110);
    check("ic_ifid_hold",  ifid_valid,  1'b0);
    check("ic_ex_bubble2", ex_bubble,   1'b1);
    icache_stall = 1'b0;
    #1;
    check("ic_refill_en",  load_if_id,  1'b1);
    cyc();
    check("ic_ifid_set",   ifid_valid,  1'b1);
    check("ic_stage3",     stage_valid, 3'b100);

    // Fill the pipe, then redirect under a data stall: nothing moves until release.
    set_id(1'b1, 1'b0, 3'd4, 3'd0, 3'd0, 2'b00);
    cyc(); cyc(); cyc();
    check("rd_full", stage_valid, 3'b111);
    dcache_stall = 1'b1;
    redirect     = 1'b1;
    #1;
    check("ds_pipe_adv",   pipe_adv,    1'b0);
    check("ds_load_pc",    load_pc,     1'b0);
    check("ds_flush",      flush_if_id, 1'b0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      check($sformatf("ds_stage_c%0d", c), stage_valid, 3'b111);
    end
    check("ds_ifid_hold",  ifid_valid,  1'b1);
    check("ds_flush_cnt",  flush_cnt,   16'd0);
    check("ds_hazard_cnt", hazard_cnt,  16'd1);
    dcache_stall = 1'b0;
    set_id(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00);
    #1;
    check("rd_flush_if_id", flush_if_id, 1'b1);
    check("rd_load_pc",     load_pc,     1'b1);
    check("rd_load_if_id",  load_if_id,  1'b0);
    check("rd_ex_bubble",   ex_bubble,   1'b1);
    cyc();
    redirect = 1'b0;
    check("rd_stage",      stage_valid, 3'b000);
    check("rd_ifid",       ifid_valid,  1'b0);
    check("rd_flush_cnt",  flush_cnt,   16'd1);
    cyc();
    check("rd_refill",     ifid_valid,  1'b1);

    // Repeated load-use stalls: counter saturates at all-ones and stays there.
    for (int h = 0; h < 14; h++) begin
      set_id(1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 2'b00);
      cyc();
      set_id(1'b1, 1'b0, 3'd2, 3'd1, 3'd0, 2'b01);
      cyc();
    end
    check("sat_main_15",   hazard_cnt,   16'd15);
    check("sat_narrow_max", n_hazard_cnt, 4'hF);
    set_id(1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 2'b00);
    cyc();
    set_id(1'b1, 1'b0, 3'd2, 3'd1, 3'd0, 2'b01);
    cyc();
    check("sat_main_16",    hazard_cnt,   16'd16);
    check("sat_narrow_hold", n_hazard_cnt, 4'hF);

    // Reset in the middle of a load-use stall clears everything at once.
    set_id(1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 2'b00);
    cyc();
    set_id(1'b1, 1'b1, 3'd1, 3'd2, 3'd0, 2'b01);
    cyc();
    set_id(1'b1, 1'b0, 3'd3, 3'd1, 3'd0, 2'b01);
    #1;
    check("mh_hazard",     ex_bubble,   1'b1);
    check("mh_fwd_sel",    fwd_sel,     4'h1);
    #1;
    reset = 1'b1;
    #1;
    check("mr_stage_valid", stage_valid, 3'b000);
    check("mr_fwd_sel",     fwd_sel,     4'h0);
    check("mr_ifid_valid",  ifid_valid,  1'b0);
    check("mr_ex_bubble",   ex_bubble,   1'b1);
    check("mr_hazard_cnt",  hazard_cnt,  16'h0);
    check("mr_narrow_cnt",  n_hazard_cnt, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- NUM_STAGES, 3, tracked stages downstream of decode; index 0=EX, NUM_STAGES-1=WB.
- NUM_SRC, 2, source-register operands per instruction.
- AW, 3, register-address width.
- LOAD_FWD_STAGE, 2, lowest stage index at which load data is forwardable.
- REDIRECT_STAGE, 2, stage index that asserts redirect.
- CNT_W, 16, event-counter width.
REQ-002 Ports SHALL be (name direction width meaning), one per line; FW = $clog2(NUM_STAGES):
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- icache_stall  in  1  fetch word not yet available.
- dcache_stall  in  1  data access outstanding; freezes the whole pipe.
- redirect  in  1  control transfer resolved at REDIRECT_STAGE.
- id_sr  in  NUM_SRC*AW  ID source registers.
- id_sr_used  in  NUM_SRC  per-source used flag.
- id_dest  in  AW  ID destination register.
- id_we  in  1  ID instruction writes the regfile.
- id_is_load  in  1  ID instruction is a memory load.
- load_pc  out  1  PC register enable.
- load_if_id  out  1  IF/ID register enable.
- flush_if_id  out  1  IF/ID content is killed.
- pipe_adv  out  1  enable for ID/EX and all later stage registers.
- ex_bubble  out  1  ID/EX receives NOP controls this edge.
- ifid_valid  out  1  IF/ID holds a live instruction.
- stage_valid  out  NUM_STAGES  per-stage live flag.
- fwd_sel  out  NUM_SRC*FW  per-source forward select for EX.
- hazard_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  redirect events.

Function
REQ-003 The block SHALL keep a scoreboard shift register of NUM_STAGES entries {valid, we, is_load, dest, sr, sr_used}.
REQ-004 pipe_adv SHALL equal !dcache_stall; while it is 0, all state and counters SHALL hold and redirect SHALL be ignored.
REQ-005 The match for an ID source SHALL be the youngest (lowest index) valid entry with we=1, dest equal to the source, and the source's sr_used=1.
REQ-006 hazard SHALL be 1 when ifid_valid=1 and any used source's match is a load at index k < LOAD_FWD_STAGE-1.
REQ-007 load_if_id SHALL be pipe_adv & !icache_stall & !hazard & !redirect.
REQ-008 load_pc SHALL be pipe_adv & (redirect | (!icache_stall & !hazard)).
REQ-009 flush_if_id SHALL be pipe_adv & redirect.
REQ-010 ex_bubble SHALL be !(ifid_valid & !hazard & !redirect).
REQ-011 On pipe_adv: entry[k] SHALL take entry[k-1]; entry[0] SHALL take the ID fields, or an invalid entry when ex_bubble=1.
REQ-012 On pipe_adv with redirect: entries 0..REDIRECT_STAGE SHALL become invalid on that edge, and ifid_valid SHALL become 0.
REQ-013 Otherwise ifid_valid SHALL be set when load_if_id=1, cleared when the IF/ID instruction moves to EX without a refill, and held in all other cases.
REQ-014 fwd_sel[i] SHALL be the index k in 1..NUM_STAGES-1 of the youngest match for entry[0].sr[i], or 0 (register-file value) when there is no match or entry[0] is invalid; it is combinational, 0 cycles.
REQ-015 Priority SHALL be reset > dcache_stall > redirect > hazard > icache_stall.
REQ-016 hazard_cnt SHALL increment on each pipe_adv cycle with hazard=1, and flush_cnt on each pipe_adv cycle with redirect=1; both SHALL saturate at all-ones.

Reset
REQ-017 Reset SHALL clear every scoreboard entry, ifid_valid and both counters immediately, including mid-stall or mid-redirect.
REQ-018 While reset is held, outputs SHALL be stage_valid=0, fwd_sel=0, ex_bubble=1, ifid_valid=0, and counters 0.

Structure
REQ-019 The scoreboard entry typedef and the fwd_sel encoding constants (FWD_RF=0) SHALL live in lc3b_types.
REQ-020 One sub-module, youngest_match, SHALL return the hit flag, index and is_load for a single source; it is instantiated per source for ID and for EX.

Verification
REQ-021 The bench SHALL cover these scenarios:
- LDR R1 in EX, ADD R2,R1,R3 in ID -> hazard=1, ex_bubble=1, load_pc=0 for 1 cycle, hazard_cnt=1.
- ADD R1 in MEM, ADD R1 in WB, EX reads R1 -> fwd_sel=1 (youngest wins).
- dcache_stall=1 for 5 cycles with redirect=1 -> no state change; on release, stages 0..2 invalid and flush_cnt=1.
- icache_stall=1 with a valid ADD in IF/ID -> ADD enters EX once, then ifid_valid=0 and ex_bubble=1 until the fetch completes.
- hazard_cnt=16'hFFFF plus one more load-use cycle -> stays 16'hFFFF.
- Reset asserted mid-hazard -> stage_valid=0 and fwd_sel=0 in the same cycle.
